// File: rtl/divider_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_arb_pkg
// Purpose  : Shared types and widths for divider_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package div_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int DIVISOR_W  = 7;
  localparam int DIVIDEND_W = 8;
  localparam int QUOT_W     = 8;
  localparam int REM_W      = 7;

  localparam logic [QUOT_W-1:0] DZ_QUOTIENT = 8'hFF;

  localparam int TIMEOUT_CYCLES = 63;
  localparam int TMO_W          = 6;

endpackage
`default_nettype wire

// File: rtl/divider_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : divider_arbiter_if
// Purpose  : Request, divider and response bundle of divider_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface divider_arbiter_if #(
  parameter int N_REQ = 4
);
  import div_arb_pkg::*;

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]            req;
  logic [DIVISOR_W*N_REQ-1:0]  req_divisor;
  logic [DIVIDEND_W*N_REQ-1:0] req_dividend;
  logic [N_REQ-1:0]            gnt;

  logic [DIVISOR_W-1:0]        div_divisor;
  logic [DIVIDEND_W-1:0]       div_dividend;
  logic                        div_start;
  logic [QUOT_W-1:0]           div_quotient;
  logic [REM_W-1:0]            div_remainder;
  logic                        div_valid;

  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [ID_W-1:0]             rsp_id;
  logic [QUOT_W-1:0]           rsp_quotient;
  logic [REM_W-1:0]            rsp_remainder;
  logic                        rsp_dz;
  logic                        rsp_err;
  logic                        busy;

  // Arbiter side
  modport slave (
    input  req, req_divisor, req_dividend,
    input  div_quotient, div_remainder, div_valid,
    input  rsp_ready,
    output gnt, div_divisor, div_dividend, div_start,
    output rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dz, rsp_err,
    output busy
  );

  // Client and divider side
  modport master (
    output req, req_divisor, req_dividend,
    output div_quotient, div_remainder, div_valid,
    output rsp_ready,
    input  gnt, div_divisor, div_dividend, div_start,
    input  rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dz, rsp_err,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/divider_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Combinational round-robin pick, searching upward from rr_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic             win_valid
);

  int idx;

  always_comb begin
    win_oh    = '0;
    win_valid = 1'b0;
    idx       = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_valid && req[idx]) begin
        win_oh[idx] = 1'b1;
        win_valid   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : divider_arbiter
// Purpose  : Round-robin sequencer sharing one divider among N_REQ clients.
//            Optional WAIT timeout under macro DIV_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module divider_arbiter
  import div_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  divider_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(N_REQ);

  state_e                state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
  logic [DIVIDEND_W-1:0] dividend_q, dividend_d;
  logic [QUOT_W-1:0]     quot_q, quot_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic                  dz_q, dz_d;
  logic                  err_q, err_d;
  logic                  gnt_pend_q, gnt_pend_d;

  logic [N_REQ-1:0]      win_oh;
  logic                  win_valid;
  logic [ID_W-1:0]       win_id;
  logic [DIVISOR_W-1:0]  sel_divisor;
  logic [DIVIDEND_W-1:0] sel_dividend;
  logic                  tmo_hit;
  logic [N_REQ-1:0]      gnt_w;

  rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_picker (
    .req       (bus.req),
    .rr_ptr    (rr_ptr_q),
    .win_oh    (win_oh),
    .win_valid (win_valid)
  );

  always_comb begin
    win_id       = '0;
    sel_divisor  = '0;
    sel_dividend = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) begin
        win_id       = ID_W'(i);
        sel_divisor  = bus.req_divisor[DIVISOR_W*i +: DIVISOR_W];
        sel_dividend = bus.req_dividend[DIVIDEND_W*i +: DIVIDEND_W];
      end
    end
  end

`ifdef DIV_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Zero outside WAIT, so the count starts at 0 on every WAIT entry
  always_comb tmo_cnt_d = (state_q == ST_WAIT) ? tmo_cnt_q + TMO_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (!reset) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end

  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    divisor_d  = divisor_q;
    dividend_d = dividend_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dz_d       = dz_q;
    err_d      = err_q;
    gnt_pend_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          id_d       = win_id;
          divisor_d  = sel_divisor;
          dividend_d = sel_dividend;
          err_d      = 1'b0;
          if (sel_divisor == '0) begin
            quot_d     = DZ_QUOTIENT;
            rem_d      = sel_dividend[REM_W-1:0];
            dz_d       = 1'b1;
            gnt_pend_d = 1'b1;
            state_d    = ST_RESP;
          end else begin
            dz_d    = 1'b0;
            state_d = ST_START;
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // A result arriving on the timeout cycle still wins
        if (bus.div_valid) begin
          quot_d  = bus.div_quotient;
          rem_d   = bus.div_remainder;
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          quot_d  = '0;
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rr_ptr_d = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dz_q       <= 1'b0;
      err_q      <= 1'b0;
      gnt_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      divisor_q  <= divisor_d;
      dividend_q <= dividend_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dz_q       <= dz_d;
      err_q      <= err_d;
      gnt_pend_q <= gnt_pend_d;
    end
  end

  // Divider jobs grant in START; zero-divisor jobs grant in their first RESP cycle
  always_comb begin
    gnt_w = '0;
    if ((state_q == ST_START) || ((state_q == ST_RESP) && gnt_pend_q))
      gnt_w[id_q] = 1'b1;
  end

  assign bus.gnt           = gnt_w;
  assign bus.div_start     = (state_q == ST_START);
  assign bus.div_divisor   = divisor_q;
  assign bus.div_dividend  = dividend_q;
  assign bus.rsp_valid     = (state_q == ST_RESP);
  assign bus.rsp_id        = id_q;
  assign bus.rsp_quotient  = quot_q;
  assign bus.rsp_remainder = rem_q;
  assign bus.rsp_dz        = dz_q;
  assign bus.rsp_err       = err_q;
  assign bus.busy          = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_arbiter
// Purpose  : Self-checking bench for divider_arbiter with a divider model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_arbiter;
  import div_arb_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  divider_arbiter_if #(.N_REQ(N)) bus();
  divider_arbiter #(.N_REQ(N)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  // Divider model: fixed 9-cycle latency, optionally never answers
  int         m_cnt   = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_q     = '0;
  logic [6:0] m_r     = '0;
  bit         m_never = 1'b0;

  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (!rst_n) begin
      m_cnt <= 0;
    end else if (bus.div_start) begin
      m_cnt <= 9;
      m_q   <= bus.div_dividend / {1'b0, bus.div_divisor};
      m_r   <= 7'(bus.div_dividend % {1'b0, bus.div_divisor});
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !m_never) m_valid <= 1'b1;
    end
  end

  assign bus.div_valid     = m_valid;
  assign bus.div_quotient  = m_q;
  assign bus.div_remainder = m_r;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] q;
    logic [6:0] r;
    logic       dz;
    logic       err;
  } rsp_t;

  rsp_t sb_q[$];
  rsp_t mon_act, mon_exp;

  function automatic void push(input int id, input logic [7:0] q, input logic [6:0] r,
                               input logic dz, input logic err);
    sb_q.push_back({2'(id), q, r, dz, err});
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      mon_act = {bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dz, bus.rsp_err};
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got %0h want no response", mon_act);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("rsp", 32'(mon_act), 32'(mon_exp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic [6:0] dvr, input logic [7:0] dvd);
    bus.req_divisor[7*id +: 7]  = dvr;
    bus.req_dividend[8*id +: 8] = dvd;
    bus.req[id]                 = 1'b1;
  endtask

  task automatic wait_gnt(output int lat);
    lat = 0;
    while (bus.gnt == '0 && lat < 40) begin
      tick();
      lat++;
    end
    if (bus.gnt == '0) begin
      total++;
      bad++;
      $display("FAIL gnt_wait: got no grant want grant within 40 cycles");
    end
  endtask

  task automatic wait_rsp(input int limit, output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < limit) begin
      tick();
      lat++;
    end
    if (!bus.rsp_valid) begin
      total++;
      bad++;
      $display("FAIL rsp_wait: got no rsp_valid want rsp_valid within %0d cycles", limit);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
    if (bus.busy) begin
      total++;
      bad++;
      $display("FAIL idle_wait: got busy=1 want busy=0 within 200 cycles");
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, 32'({bus.gnt, bus.div_start, bus.div_divisor, bus.div_dividend, bus.busy}), 32'd0);
    chk({tag, "_rsp"}, 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder,
                            bus.rsp_dz, bus.rsp_err}), 32'd0);
  endtask

  typedef struct {
    int         id;
    logic [6:0] dvr;
    logic [7:0] dvd;
    logic [7:0] q;
    logic [6:0] r;
    logic       dz;
  } vec_t;

  vec_t       tbl[8];
  logic [7:0] rr_q[4];
  logic [6:0] rr_r[4];

  initial begin
    int lat;
    int hold;
    tbl[0] = '{0, 7'd5,   8'd100, 8'd20,  7'd0,  1'b0};
    tbl[1] = '{1, 7'd7,   8'd200, 8'd28,  7'd4,  1'b0};
    tbl[2] = '{2, 7'd0,   8'd200, 8'hFF,  7'd72, 1'b1};
    tbl[3] = '{3, 7'd127, 8'd255, 8'd2,   7'd1,  1'b0};
    tbl[4] = '{0, 7'd1,   8'd0,   8'd0,   7'd0,  1'b0};
    tbl[5] = '{1, 7'd9,   8'd8,   8'd0,   7'd8,  1'b0};
    tbl[6] = '{3, 7'd0,   8'd5,   8'hFF,  7'd5,  1'b1};
    tbl[7] = '{2, 7'd100, 8'd255, 8'd2,   7'd55, 1'b0};
    rr_q = '{8'd3, 8'd6, 8'd10, 8'd13};
    rr_r = '{7'd1, 7'd2, 7'd0,  7'd1};

    bus.req          = '0;
    bus.req_divisor  = '0;
    bus.req_dividend = '0;
    bus.rsp_ready    = 1'b1;
    rst_n            = 1'b0;
    repeat (3) tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Single request, 5/100
    push(0, 8'd20, 7'd0, 1'b0, 1'b0);
    drive(0, 7'd5, 8'd100);
    wait_gnt(lat);
    chk("single_lat", 32'(lat), 32'd1);
    chk("single_gnt", 32'(bus.gnt), 32'b0001);
    chk("single_start", 32'(bus.div_start), 32'd1);
    chk("single_ops", 32'({bus.div_divisor, bus.div_dividend}), 32'({7'd5, 8'd100}));
    bus.req = '0;
    tick();
    chk("single_pulse", 32'({bus.gnt, bus.div_start}), 32'd0);
    wait_rsp(40, lat);
    tick();
    chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
    wait_idle();

    // Vector table: grant latency and grant-cycle outputs per job
    for (int k = 0; k < 8; k++) begin
      push(tbl[k].id, tbl[k].q, tbl[k].r, tbl[k].dz, 1'b0);
      drive(tbl[k].id, tbl[k].dvr, tbl[k].dvd);
      wait_gnt(lat);
      chk($sformatf("vec%0d_lat", k), 32'(lat), 32'd1);
      chk($sformatf("vec%0d_gnt", k), 32'(bus.gnt), 32'(1 << tbl[k].id));
      if (tbl[k].dz) begin
        chk($sformatf("vec%0d_dz_nostart", k), 32'(bus.div_start), 32'd0);
        chk($sformatf("vec%0d_dz_valid", k), 32'(bus.rsp_valid), 32'd1);
      end else begin
        chk($sformatf("vec%0d_start", k), 32'(bus.div_start), 32'd1);
        chk($sformatf("vec%0d_ops", k), 32'({bus.div_divisor, bus.div_dividend}),
            32'({tbl[k].dvr, tbl[k].dvd}));
      end
      bus.req = '0;
      wait_idle();
    end

    // Round-robin with all requests held from reset
    rst_n   = 1'b0;
    bus.req = '0;
    for (int i = 0; i < N; i++) drive(i, 7'd3, 8'(10 * (i + 1)));
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_gnt(lat);
      chk($sformatf("rr%0d_gnt", k), 32'(bus.gnt), 32'(1 << (k % N)));
      push(k % N, rr_q[k % N], rr_r[k % N], 1'b0, 1'b0);
      tick();
    end
    bus.req = '0;
    wait_idle();

    // Backpressure: response held while req[1] waits
    bus.rsp_ready = 1'b0;
    push(0, 8'd8, 7'd2, 1'b0, 1'b0);
    drive(0, 7'd6, 8'd50);
    wait_gnt(lat);
    tick();
    bus.req = '0;
    drive(1, 7'd4, 8'd9);
    wait_rsp(40, lat);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_hold%0d", c),
          32'({bus.rsp_valid, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder,
               bus.rsp_dz, bus.rsp_err, bus.gnt}),
          32'({1'b1, 2'd0, 8'd8, 7'd2, 1'b0, 1'b0, 4'b0000}));
      tick();
    end
    bus.rsp_ready = 1'b1;
    push(1, 8'd2, 7'd1, 1'b0, 1'b0);
    tick();
    chk("bp_r1", 32'({bus.gnt, bus.busy}), 32'd0);
    tick();
    chk("bp_r2_gnt", 32'(bus.gnt), 32'b0010);
    bus.req = '0;
    tick();
    wait_idle();

    // Reset during WAIT: job for id3 discarded, pointer back to 0
    drive(3, 7'd1, 8'd1);
    wait_gnt(lat);
    bus.req = '0;
    drive(1, 7'd4, 8'd9);
    drive(2, 7'd10, 8'd77);
    tick();
    chk("mid_in_wait", 32'({bus.busy, bus.div_start}), 32'b10);
    rst_n = 1'b0;
    tick();
    chk_reset_vals("mid_reset");
    rst_n = 1'b1;
    push(1, 8'd2, 7'd1, 1'b0, 1'b0);
    tick();
    chk("mid_next_gnt", 32'(bus.gnt), 32'b0010);
    bus.req = '0;
    tick();
    wait_idle();

    // Divider that never answers
    m_never = 1'b1;
    drive(0, 7'd3, 8'd9);
    wait_gnt(lat);
    bus.req = '0;
    tick();
`ifdef DIV_ARB_TIMEOUT_EN
    push(0, 8'd0, 7'd0, 1'b0, 1'b1);
    wait_rsp(100, lat);
    chk("tmo_lat", 32'(lat), 32'd64);
    chk("tmo_err", 32'(bus.rsp_err), 32'd1);
    tick();
    wait_idle();
`else
    hold = 0;
    for (int c = 0; c < 200; c++) begin
      if (bus.busy && !bus.rsp_valid) hold++;
      tick();
    end
    chk("tmo_busy_hold", 32'(hold), 32'd200);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`endif
    m_never = 1'b0;

    repeat (3) tick();
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
